// File: rtl/prio_rr_arbiter.sv
// N-way arbiter with registered one-hot grant, fixed-priority or round-robin
// selection, and a bounded hold so a persistent owner cannot starve the others.
module prio_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  localparam int              HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0]  ID_LAST   = IDW'(N - 1);
  localparam logic [IDW:0]    N_EXT     = (IDW+1)'(N);

  logic [IDW-1:0] cur_q, cur_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic [N-1:0]   cur_oh;
  logic [N-1:0]   others;
  logic [N-1:0]   arb_req;
  logic           owner_req;
  logic           arb_en;
  logic [IDW-1:0] win;

  // First set bit at or after start, wrapping modulo N (start=0 gives fixed priority).
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] start);
    logic           found;
    logic [IDW-1:0] w;
    logic [IDW:0]   s;
    logic [IDW-1:0] idx;
    found = 1'b0;
    w     = '0;
    for (int i = 0; i < N; i++) begin
      s = {1'b0, start} + (IDW+1)'(i);
      if (s >= N_EXT) s = s - N_EXT;
      idx = s[IDW-1:0];
      if (!found && r[idx]) begin
        found = 1'b1;
        w     = idx;
      end
    end
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      cur_q   <= cur_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    cur_oh    = N'(1) << cur_q;
    owner_req = valid_q && ((req & cur_oh) != '0);
    others    = req & ~cur_oh;
    arb_req   = req;
    arb_en    = 1'b0;
    cur_d     = cur_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;

    if (owner_req && hold_q != HOLD_LAST) begin
      hold_d = hold_q + HW'(1);
    end else if (owner_req) begin
      // Hold budget spent: hand over only if someone else is actually waiting.
      if (others != '0) begin
        arb_en  = 1'b1;
        arb_req = others;
      end else begin
        hold_d = '0;
      end
    end else if (req == '0) begin
      valid_d = 1'b0;
      hold_d  = '0;
    end else begin
      arb_en = 1'b1;
    end

    win = pick(arb_req, mode ? ptr_q : '0);

    if (arb_en) begin
      cur_d   = win;
      valid_d = 1'b1;
      hold_d  = '0;
      ptr_d   = (win == ID_LAST) ? '0 : win + IDW'(1);
    end
  end

  always_comb begin
    gnt       = valid_q ? (N'(1) << cur_q) : '0;
    gnt_id    = cur_q;
    gnt_valid = valid_q;
  end

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed bench for prio_rr_arbiter (N=4, MAX_HOLD=4) with hand-computed grant sequences.
module tb_prio_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  int checks = 0;
  int errors = 0;

  prio_rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    req  = 4'b0000;
    mode = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [3:0] exp_fix [12] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                               4'b1000, 4'b1000, 4'b1000, 4'b1000,
                               4'b0010, 4'b0010, 4'b0010, 4'b0010};
  logic [3:0] rr_req  [5]  = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] rr_gnt  [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] rr_id   [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    // reset held under full load
    rst  = 1'b0;
    mode = 1'b0;
    req  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_gnt", gnt, 4'b0000);
      check_val("rst_valid", 4'(gnt_valid), 4'b0000);
      check_val("rst_id", 4'(gnt_id), 4'd0);
    end
    rst = 1'b1;
    tick();
    check_val("first_gnt", gnt, 4'b0001);
    check_val("first_id", 4'(gnt_id), 4'd0);
    check_val("first_valid", 4'(gnt_valid), 4'b0001);
    #3 rst = 1'b0;
    #1;
    check_val("async_rst_gnt", gnt, 4'b0000);
    check_val("async_rst_valid", 4'(gnt_valid), 4'b0000);

    // fixed priority with hold expiry
    do_reset();
    mode = 1'b0;
    req  = 4'b1010;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_val($sformatf("fix_exp[%0d]", i), gnt, exp_fix[i]);
    end

    // round-robin rotation, owner drops after its grant
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req = rr_req[i];
      tick();
      check_val($sformatf("rr_gnt[%0d]", i), gnt, rr_gnt[i]);
      check_val($sformatf("rr_id[%0d]", i), 4'(gnt_id), 4'(rr_id[i]));
    end

    // lone requester across the hold boundary, both modes
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      mode = (i >= 5);
      tick();
      check_val($sformatf("lone[%0d]", i), gnt, 4'b0100);
    end

    // release to idle, then a fresh request
    req = 4'b0000;
    tick();
    check_val("idle_gnt", gnt, 4'b0000);
    check_val("idle_valid", 4'(gnt_valid), 4'b0000);
    req = 4'b0001;
    tick();
    check_val("wake_gnt", gnt, 4'b0001);
    check_val("wake_id", 4'(gnt_id), 4'd0);
    check_val("wake_valid", 4'(gnt_valid), 4'b0001);

    // mode switch during a hold: fixed priority picks bit 0 at expiry (RR would pick bit 2)
    do_reset();
    mode = 1'b1;
    req  = 4'b0010;
    tick();
    check_val("msw_grant", gnt, 4'b0010);
    req = 4'b1111;
    tick();
    check_val("msw_hold1", gnt, 4'b0010);
    mode = 1'b0;
    tick();
    check_val("msw_hold2", gnt, 4'b0010);
    tick();
    check_val("msw_hold3", gnt, 4'b0010);
    tick();
    check_val("msw_expire", gnt, 4'b0001);
    check_val("msw_expire_id", 4'(gnt_id), 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
